hit_round_ctrl: RTL and testbench
=================================

HIT_ROUND_CTRL -- requirements
Module: hit_round_ctrl

Interface
REQ-001 Parameter DB_CYCLES, default 500000: debounce stability length, in clocks.
REQ-002 Parameter WIN1, default 100000000: level-1 target window, in clocks.
REQ-003 Parameter WIN2, default 75000000: level-2 target window, in clocks.
REQ-004 Parameter WIN3, default 50000000: level-3 target window, in clocks.
REQ-005 CLOCK_50  in  1  sole clock; all logic SHALL be on its rising edge.
REQ-006 resetn  in  1  synchronous, active-low reset.
REQ-007 enable  in  1  game-running level; round sequencing SHALL run only while high.
REQ-008 sensor_raw  in  3  asynchronous box code from the Arduino; 3'b000 means no press.
REQ-009 lfsr_value  in  3  candidate target box; 3'b000 means invalid.
REQ-010 difficulty_level  in  2  1..3; value 0 SHALL be treated as 1.
REQ-011 target_box  out  3  current target; registered.
REQ-012 target_valid  out  1  high only in ARMED.
REQ-013 hit_strobe  out  1  one-cycle pulse: pressed box equals target.
REQ-014 miss_strobe  out  1  one-cycle pulse: pressed box differs from target.
REQ-015 timeout_strobe  out  1  one-cycle pulse: window expired without a press.
REQ-016 hit_box  out  3  debounced box latched at each hit or miss.
REQ-017 round_count  out  8  rounds ended; saturates at 255.

Function
REQ-018 sensor_raw SHALL pass through a 2-flop synchronizer before any other use.
REQ-019 Debounce: the synchronized code SHALL become the debounced code db only after it has been stable for DB_CYCLES consecutive clocks.
REQ-020 Debounce: a change in the synchronized code SHALL restart its stability count.
REQ-021 A press event SHALL be a db transition from 000 to a nonzero code.
REQ-022 Latency: a strobe SHALL go high DB_CYCLES+4 rising edges after sensor_raw settles.
REQ-023 The FSM SHALL have exactly four states: IDLE, LOAD, ARMED, COOLDOWN.
REQ-024 IDLE: go to LOAD when enable is high.
REQ-025 LOAD: if lfsr_value is 000, remain in LOAD and retry the next cycle.
REQ-026 LOAD: otherwise, latch target_box=lfsr_value and load the window counter with WINx-1 (x = effective level), then go to ARMED.
REQ-027 ARMED: on a press event, pulse hit_strobe if db equals target_box, else pulse miss_strobe; latch hit_box=db; go to COOLDOWN.
REQ-028 ARMED: with no press event, a counter of 0 SHALL pulse timeout_strobe and go to LOAD; otherwise decrement the counter.
REQ-029 A press event and counter==0 in the same cycle SHALL resolve as a press: hit or miss is pulsed, timeout is not.
REQ-030 COOLDOWN: go to LOAD once db equals 000; a held press SHALL not retrigger.
REQ-031 A press already held when ARMED is entered SHALL NOT count; only a fresh 000-to-nonzero transition counts.
REQ-032 At most one strobe SHALL be high in any cycle.
REQ-033 round_count SHALL increment on every strobe, saturating at 255.
REQ-034 difficulty_level SHALL be sampled only in LOAD; changes during ARMED SHALL not affect the current window.
REQ-035 enable low in any state SHALL force IDLE on the next edge with target_valid=0, no strobe, and the debouncer still running.
REQ-036 round_count and hit_box SHALL be held while enable is low.

Reset
REQ-037 While resetn is low at a rising edge, the block SHALL enter IDLE.
REQ-038 Reset values: target_box=0, target_valid=0, all strobes=0, hit_box=0, round_count=0, db=000, synchronizer=000, all counters=0.
REQ-039 Reset asserted mid-round SHALL abort the round with no strobe; after release, the block SHALL behave as from power-up.

Verification (DB_CYCLES=4, WIN1=20, WIN2=15, WIN3=10)
REQ-040 Hit: enable=1, lfsr_value=3, level 1; sensor_raw=3 held 10 clocks from cycle 2 of ARMED -> hit_strobe pulses once 8 edges after the change, hit_box=3, round_count=1.
REQ-041 Miss plus cooldown: target 5, press 2 held 50 clocks -> miss_strobe once, no further strobe until released and debounced, then LOAD.
REQ-042 Timeout per level: no press at levels 1/2/3 -> timeout_strobe after exactly 20/15/10 ARMED cycles; level 0 gives 20.
REQ-043 Glitch rejection: 3-clock pulses of sensor_raw=4 -> no db change, no strobe.
REQ-044 Simultaneous events and invalid target: press event on the counter==0 cycle -> hit or miss only; lfsr_value=0 for 5 cycles -> LOAD held, target_valid=0.
REQ-045 Reset and saturation: resetn low mid-ARMED -> all outputs at reset values next edge; 300 timeouts -> round_count=255.

Source files
------------

// File: rtl/hit_round_ctrl.sv
// Round controller: debounces the box sensor and scores hit/miss/timeout against a random target box.
// Latency: strobe DB_CYCLES+4 edges after sensor_raw settles; timeout after WINx armed cycles.
// No backpressure: strobes are one-cycle pulses and must be taken when they occur.
module hit_round_ctrl #(
  parameter int DB_CYCLES = 500000,
  parameter int WIN1      = 100000000,
  parameter int WIN2      = 75000000,
  parameter int WIN3      = 50000000
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic       enable,
  input  logic [2:0] sensor_raw,
  input  logic [2:0] lfsr_value,
  input  logic [1:0] difficulty_level,
  output logic [2:0] target_box,
  output logic       target_valid,
  output logic       hit_strobe,
  output logic       miss_strobe,
  output logic       timeout_strobe,
  output logic [2:0] hit_box,
  output logic [7:0] round_count
);

  localparam int DBW  = $clog2(DB_CYCLES + 1);
  localparam int WMAX = (WIN1 > WIN2) ? ((WIN1 > WIN3) ? WIN1 : WIN3)
                                      : ((WIN2 > WIN3) ? WIN2 : WIN3);
  localparam int WW   = $clog2(WMAX + 1);

  localparam logic [DBW-1:0] DB_LAST = DBW'(DB_CYCLES - 1);
  localparam logic [WW-1:0]  W1_LOAD = WW'(WIN1 - 1);
  localparam logic [WW-1:0]  W2_LOAD = WW'(WIN2 - 1);
  localparam logic [WW-1:0]  W3_LOAD = WW'(WIN3 - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_ARMED = 2'd2;
  localparam logic [1:0] S_COOL  = 2'd3;

  logic [2:0]     sync1;
  logic [2:0]     sync2;
  logic [2:0]     sync_hold;
  logic [2:0]     db;
  logic [2:0]     db_d;
  logic [DBW-1:0] db_cnt;
  logic [1:0]     state;
  logic [WW-1:0]  win_cnt;
  logic [WW-1:0]  win_load;
  logic [7:0]     round_next;
  logic           press;

  // sync_hold tracks the last synchronized code; any change restarts the stability count
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      sync1     <= 3'b000;
      sync2     <= 3'b000;
      sync_hold <= 3'b000;
      db        <= 3'b000;
      db_d      <= 3'b000;
      db_cnt    <= '0;
    end else begin
      sync1 <= sensor_raw;
      sync2 <= sync1;
      db_d  <= db;
      if (sync2 != sync_hold) begin
        sync_hold <= sync2;
        db_cnt    <= '0;
      end else if (db_cnt != DB_LAST) begin
        db_cnt <= db_cnt + DBW'(1);
      end else begin
        db <= sync_hold;
      end
    end
  end

  assign press        = (db_d == 3'b000) && (db != 3'b000);
  assign target_valid = (state == S_ARMED);
  assign round_next   = (round_count == 8'hFF) ? round_count : round_count + 8'd1;

  always_comb begin
    win_load = W1_LOAD;
    case (difficulty_level)
      2'd2:    win_load = W2_LOAD;
      2'd3:    win_load = W3_LOAD;
      default: win_load = W1_LOAD;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      state          <= S_IDLE;
      target_box     <= 3'b000;
      hit_strobe     <= 1'b0;
      miss_strobe    <= 1'b0;
      timeout_strobe <= 1'b0;
      hit_box        <= 3'b000;
      round_count    <= 8'd0;
      win_cnt        <= '0;
    end else begin
      hit_strobe     <= 1'b0;
      miss_strobe    <= 1'b0;
      timeout_strobe <= 1'b0;
      if (!enable) begin
        state <= S_IDLE;
      end else begin
        case (state)
          S_IDLE: state <= S_LOAD;
          S_LOAD: begin
            if (lfsr_value != 3'b000) begin
              target_box <= lfsr_value;
              win_cnt    <= win_load;
              state      <= S_ARMED;
            end
          end
          // a press wins over an expiring window in the same cycle
          S_ARMED: begin
            if (press) begin
              if (db == target_box) hit_strobe <= 1'b1;
              else                  miss_strobe <= 1'b1;
              hit_box     <= db;
              round_count <= round_next;
              state       <= S_COOL;
            end else if (win_cnt == '0) begin
              timeout_strobe <= 1'b1;
              round_count    <= round_next;
              state          <= S_LOAD;
            end else begin
              win_cnt <= win_cnt - WW'(1);
            end
          end
          S_COOL: begin
            if (db == 3'b000) state <= S_LOAD;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hit_round_ctrl.sv
// Directed bench for hit_round_ctrl with short debounce and window parameters.
module tb_hit_round_ctrl;

  logic       CLOCK_50 = 1'b0;
  logic       resetn;
  logic       enable;
  logic [2:0] sensor_raw;
  logic [2:0] lfsr_value;
  logic [1:0] difficulty_level;
  logic [2:0] target_box;
  logic       target_valid;
  logic       hit_strobe;
  logic       miss_strobe;
  logic       timeout_strobe;
  logic [2:0] hit_box;
  logic [7:0] round_count;

  int checks = 0;
  int errors = 0;
  int multi_strobe = 0;

  logic [1:0] lvl_tab [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
  int         win_tab [4] = '{20, 15, 10, 20};

  always #5 CLOCK_50 = ~CLOCK_50;

  hit_round_ctrl #(
    .DB_CYCLES(4),
    .WIN1(20),
    .WIN2(15),
    .WIN3(10)
  ) dut (
    .CLOCK_50(CLOCK_50),
    .resetn(resetn),
    .enable(enable),
    .sensor_raw(sensor_raw),
    .lfsr_value(lfsr_value),
    .difficulty_level(difficulty_level),
    .target_box(target_box),
    .target_valid(target_valid),
    .hit_strobe(hit_strobe),
    .miss_strobe(miss_strobe),
    .timeout_strobe(timeout_strobe),
    .hit_box(hit_box),
    .round_count(round_count)
  );

  always @(negedge CLOCK_50)
    if ($countones({hit_strobe, miss_strobe, timeout_strobe}) > 1) multi_strobe++;

  task automatic tick;
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic wait_armed(output int n);
    n = 0;
    while (target_valid !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset;
    resetn = 1'b0; enable = 1'b0; sensor_raw = 3'd0; lfsr_value = 3'd0; difficulty_level = 2'd0;
    tick(); tick();
    checks++;
    if ({target_box, target_valid} !== 4'b0) begin
      errors++; $display("FAIL reset_target: got box=%0d valid=%0b, expected 0/0", target_box, target_valid);
    end
    checks++;
    if ({hit_strobe, miss_strobe, timeout_strobe} !== 3'b000) begin
      errors++; $display("FAIL reset_strobes: got %b, expected 000", {hit_strobe, miss_strobe, timeout_strobe});
    end
    checks++;
    if (hit_box !== 3'd0 || round_count !== 8'd0) begin
      errors++; $display("FAIL reset_counts: got hit_box=%0d round_count=%0d, expected 0/0", hit_box, round_count);
    end
    enable = 1'b1; lfsr_value = 3'd3;
    tick(); tick();
    checks++;
    if (target_valid !== 1'b0) begin
      errors++; $display("FAIL reset_hold: got target_valid=%0b, expected 0", target_valid);
    end
    enable = 1'b0;
  endtask

  task automatic test_hit;
    int n, first, hits, others;
    resetn = 1'b1; enable = 1'b1; lfsr_value = 3'd3; difficulty_level = 2'd1;
    wait_armed(n);
    checks++;
    if (target_valid !== 1'b1 || target_box !== 3'd3) begin
      errors++; $display("FAIL hit_arm: got valid=%0b box=%0d, expected 1/3", target_valid, target_box);
    end
    tick();
    sensor_raw = 3'd3; first = 0; hits = 0; others = 0;
    for (int i = 1; i <= 30; i++) begin
      if (i == 11) sensor_raw = 3'd0;
      tick();
      if (hit_strobe) begin hits++; if (first == 0) first = i; end
      if (miss_strobe || timeout_strobe) others++;
    end
    checks++;
    if (first !== 8) begin
      errors++; $display("FAIL hit_latency: got %0d edges, expected 8", first);
    end
    checks++;
    if (hits !== 1 || others !== 0) begin
      errors++; $display("FAIL hit_count: got hits=%0d others=%0d, expected 1/0", hits, others);
    end
    checks++;
    if (hit_box !== 3'd3 || round_count !== 8'd1) begin
      errors++; $display("FAIL hit_latch: got hit_box=%0d round_count=%0d, expected 3/1", hit_box, round_count);
    end
    enable = 1'b0;
    tick();
    checks++;
    if (target_valid !== 1'b0) begin
      errors++; $display("FAIL hit_disable: got target_valid=%0b, expected 0", target_valid);
    end
    tick();
  endtask

  task automatic test_miss;
    int n, misses, others;
    lfsr_value = 3'd5; difficulty_level = 2'd1; enable = 1'b1;
    wait_armed(n);
    checks++;
    if (target_valid !== 1'b1 || target_box !== 3'd5) begin
      errors++; $display("FAIL miss_arm: got valid=%0b box=%0d, expected 1/5", target_valid, target_box);
    end
    sensor_raw = 3'd2; misses = 0; others = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (miss_strobe) misses++;
      if (hit_strobe || timeout_strobe) others++;
    end
    checks++;
    if (misses !== 1 || others !== 0) begin
      errors++; $display("FAIL miss_count: got misses=%0d others=%0d, expected 1/0", misses, others);
    end
    checks++;
    if (target_valid !== 1'b0 || hit_box !== 3'd2 || round_count !== 8'd2) begin
      errors++; $display("FAIL miss_cooldown: got valid=%0b hit_box=%0d round_count=%0d, expected 0/2/2",
                         target_valid, hit_box, round_count);
    end
    sensor_raw = 3'd0; n = 0; others = 0;
    while (target_valid !== 1'b1 && n < 30) begin
      tick(); n++;
      if (hit_strobe || miss_strobe || timeout_strobe) others++;
    end
    checks++;
    if (n !== 9 || others !== 0) begin
      errors++; $display("FAIL miss_rearm: got %0d edges, %0d strobes, expected 9/0", n, others);
    end
    enable = 1'b0;
    tick();
  endtask

  task automatic test_timeout;
    int n, cnt;
    logic got;
    for (int k = 0; k < 4; k++) begin
      enable = 1'b0;
      tick();
      difficulty_level = lvl_tab[k];
      enable = 1'b1;
      wait_armed(n);
      difficulty_level = ~difficulty_level;
      cnt = 1; got = 1'b0;
      for (int i = 0; i < 100 && !got; i++) begin
        tick();
        if (timeout_strobe) got = 1'b1;
        else cnt++;
      end
      checks++;
      if (!got || cnt !== win_tab[k]) begin
        errors++; $display("FAIL timeout_lvl%0d: got %0d armed cycles (seen=%0b), expected %0d",
                           lvl_tab[k], cnt, got, win_tab[k]);
      end
    end
    enable = 1'b0;
    tick(); tick(); tick();
    checks++;
    if (round_count !== 8'd6) begin
      errors++; $display("FAIL timeout_rounds: got %0d, expected 6", round_count);
    end
  endtask

  task automatic test_glitch;
    int n, strobes;
    lfsr_value = 3'd3; difficulty_level = 2'd1; enable = 1'b1;
    wait_armed(n);
    strobes = 0;
    for (int g = 0; g < 2; g++) begin
      sensor_raw = 3'd4;
      for (int i = 0; i < 3; i++) begin
        tick();
        if (hit_strobe || miss_strobe || timeout_strobe) strobes++;
      end
      sensor_raw = 3'd0;
      for (int i = 0; i < 5; i++) begin
        tick();
        if (hit_strobe || miss_strobe || timeout_strobe) strobes++;
      end
    end
    checks++;
    if (strobes !== 0) begin
      errors++; $display("FAIL glitch_strobe: got %0d strobes, expected 0", strobes);
    end
    checks++;
    if (target_valid !== 1'b1 || hit_box !== 3'd2 || round_count !== 8'd6) begin
      errors++; $display("FAIL glitch_state: got valid=%0b hit_box=%0d round_count=%0d, expected 1/2/6",
                         target_valid, hit_box, round_count);
    end
    enable = 1'b0;
    tick();
  endtask

  task automatic test_simultaneous;
    int n, early;
    lfsr_value = 3'd3; difficulty_level = 2'd3; enable = 1'b1;
    wait_armed(n);
    tick(); tick();
    sensor_raw = 3'd3; early = 0;
    for (int i = 0; i < 7; i++) begin
      tick();
      if (hit_strobe || miss_strobe || timeout_strobe) early++;
    end
    tick();
    checks++;
    if (early !== 0 || {hit_strobe, miss_strobe, timeout_strobe} !== 3'b100) begin
      errors++; $display("FAIL simul_press: got early=%0d hit/miss/tout=%b, expected 0/100",
                         early, {hit_strobe, miss_strobe, timeout_strobe});
    end
    tick();
    checks++;
    if (round_count !== 8'd7 || timeout_strobe !== 1'b0) begin
      errors++; $display("FAIL simul_rounds: got round_count=%0d tout=%0b, expected 7/0", round_count, timeout_strobe);
    end
    sensor_raw = 3'd0; enable = 1'b0;
    for (int i = 0; i < 10; i++) tick();
  endtask

  task automatic test_invalid;
    int bad;
    lfsr_value = 3'd0; enable = 1'b1; bad = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (target_valid !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++; $display("FAIL invalid_hold: got %0d armed cycles, expected 0", bad);
    end
    lfsr_value = 3'd6;
    tick();
    checks++;
    if (target_valid !== 1'b1 || target_box !== 3'd6) begin
      errors++; $display("FAIL invalid_load: got valid=%0b box=%0d, expected 1/6", target_valid, target_box);
    end
  endtask

  task automatic test_reset_mid;
    int bad;
    sensor_raw = 3'd6;
    tick(); tick();
    resetn = 1'b0;
    tick();
    checks++;
    if ({target_box, target_valid, hit_strobe, miss_strobe, timeout_strobe, hit_box, round_count} !== 18'd0) begin
      errors++; $display("FAIL reset_mid: got box=%0d valid=%0b strobes=%b hit_box=%0d rounds=%0d, expected all 0",
                         target_box, target_valid, {hit_strobe, miss_strobe, timeout_strobe}, hit_box, round_count);
    end
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (hit_strobe || miss_strobe || timeout_strobe || target_valid) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++; $display("FAIL reset_mid_quiet: got %0d active cycles, expected 0", bad);
    end
    sensor_raw = 3'd0; resetn = 1'b1;
    tick();
    checks++;
    if (target_valid !== 1'b0 || round_count !== 8'd0) begin
      errors++; $display("FAIL reset_release: got valid=%0b rounds=%0d, expected 0/0", target_valid, round_count);
    end
  endtask

  task automatic test_saturation;
    int touts, cyc;
    logic [7:0] rc255;
    difficulty_level = 2'd3; lfsr_value = 3'd1; enable = 1'b1;
    touts = 0; cyc = 0; rc255 = 8'd0;
    while (touts < 300 && cyc < 6000) begin
      tick(); cyc++;
      if (timeout_strobe) begin
        touts++;
        if (touts == 255) rc255 = round_count;
      end
    end
    checks++;
    if (touts !== 300) begin
      errors++; $display("FAIL sat_timeouts: got %0d timeouts in %0d cycles, expected 300", touts, cyc);
    end
    checks++;
    if (rc255 !== 8'd255) begin
      errors++; $display("FAIL sat_reach: got %0d at 255th timeout, expected 255", rc255);
    end
    checks++;
    if (round_count !== 8'd255) begin
      errors++; $display("FAIL sat_hold: got %0d, expected 255", round_count);
    end
  endtask

  initial begin
    test_reset();
    test_hit();
    test_miss();
    test_timeout();
    test_glitch();
    test_simultaneous();
    test_invalid();
    test_reset_mid();
    test_saturation();
    checks++;
    if (multi_strobe !== 0) begin
      errors++; $display("FAIL one_strobe: got %0d cycles with multiple strobes, expected 0", multi_strobe);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
